hack_sequencer: RTL and testbench
=================================

# hack_sequencer

Multi-cycle fetch/execute sequencer for the extended Hack CPU, and the instruction-issuing side of the extended ALU. It accepts 16-bit instructions as two bytes over a valid/ready link and holds the A, D and PC registers. It decodes each instruction into the 9-bit ALU instruction and x/y operands, then commits the ALU result to A, D and/or memory and resolves jumps from the returned zr/ng flags. It sits between the byte-wide pin interface and the combinational extended ALU.

## Interface
Parameters: none; all widths are fixed by the Hack ISA.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_byte  in  8  instruction byte, low byte first
- instr_valid  in  1  instr_byte is valid
- instr_ready  out  1  sequencer accepts a byte this cycle
- m_in  in  16  memory operand RAM[A], valid during EXEC
- alu_x  out  16  ALU x operand (D)
- alu_y  out  16  ALU y operand (A or m_in)
- alu_instr  out  9  ALU instruction
- alu_out  in  16  ALU result
- alu_zr  in  1  ALU result is zero
- alu_ng  in  1  ALU result is negative
- write_m  out  1  memory write strobe, one cycle
- m_out  out  16  write data (alu_out)
- addr_m  out  15  memory address (A[14:0])
- pc  out  15  address of the next instruction to stream in
- a_reg, d_reg  out  16  architectural registers, for debug

## Operation
- FSM states: FETCH_LO, FETCH_HI, EXEC. After reset the FSM is in FETCH_LO.
- FETCH_LO: instr_ready=1. On instr_valid&&instr_ready, latch ir[7:0] and go to FETCH_HI.
- FETCH_HI: instr_ready=1. On the transfer, latch ir[15:8] and go to EXEC. With no valid byte, hold the state (no timeout).
- EXEC: instr_ready=0. The FSM always returns to FETCH_LO on the next edge.
- A-instruction (ir[15]=0), at the EXEC edge:
  - A <= {1'b0, ir[14:0]}
  - pc <= pc+1
  - write_m stays 0
- C-instruction (ir[15]=1) decode:
  - alu_instr = {ir[14:13], ir[12], ir[11:6]}
  - ir[12] is the a-bit. alu_y = ir[12] ? m_in : A.
  - alu_x = D.
  - dest = ir[5:3] = {A, D, M}.
  - jump = ir[2:0] = {lt, eq, gt}.
- C-instruction commit, at the EXEC edge:
  - If dest.A: A <= alu_out.
  - If dest.D: D <= alu_out.
  - If dest.M: write_m=1 during EXEC, with addr_m = old A[14:0] and m_out = alu_out.
- Jump condition: (j[2]&alu_ng) | (j[1]&alu_zr) | (j[0]&~alu_ng&~alu_zr).
  - Taken: pc <= old A[14:0], i.e. the A value before this instruction's commit.
  - Not taken: pc <= pc+1.
- Encodings with ir[14:13]=11 are bit-identical to standard Hack C-instructions.
- Outside EXEC: alu_instr, alu_x and alu_y still reflect the current ir/A/D, but no state changes.
- Width rules:
  - pc increments modulo 2^15; 0x7FFF+1 = 0x0000.
  - All 16-bit values are two's complement, with no saturation.

## Timing
- Reset values:
  - state = FETCH_LO, pc = 0, A = 0, D = 0, ir = 0
  - write_m = 0, instr_ready = 1
  - addr_m = 0, m_out = alu_out, per the combinational decode of ir = 0
- Reset is asynchronous. Asserting it mid-instruction discards any partial ir and forces write_m low immediately.
- Minimum cost is 3 cycles per instruction: byte, byte, EXEC. Each extra cycle of instr_valid low adds one cycle of latency.
- write_m is high for exactly one cycle (EXEC) per C-instruction with dest.M. It is never high in the fetch states.
- A, D and pc update on the clock edge that leaves EXEC, and are visible from the following FETCH_LO cycle.
- m_in must be stable during EXEC. It is combinationally muxed into alu_y and then onto alu_out.
- A byte offered during EXEC is not accepted (instr_ready=0). The source holds it until FETCH_LO.

## Test plan
- Reset, then check idle outputs: pc=0, A=0, D=0, write_m=0, instr_ready=1, state FETCH_LO.
- Feed 0x05, 0x00 (@5), then 0x10, 0xEC (D=A) -> A=0x0005, D=0x0005, pc=2. Check for 3-cycle spacing.
- Feed @100 (0x0064), then M=D (0xE308) with D=5 -> write_m high for one cycle with addr_m=100 and m_out=5.
- Set D=0xFFFA. Feed D=D>>>1 (0xA410) -> D=0xFFFD. Then feed D;JLT (0xE304) with A=7 -> pc=7.
- Jump edge cases:
  - AM=A+1;JMP with A=3 -> pc=3 (old A) and A=4.
  - pc=0x7FFF followed by a non-jump -> pc=0x0000.
- Throttling and reset:
  - Stall instr_valid low for 5 cycles between bytes -> no state change.
  - Assert rst_n low after the low byte -> partial ir discarded; pc, A and D return to 0.

Source files
------------

// File: rtl/hack_sequencer_if.sv
// hack_sequencer_if: bundle of the signals between the Hack fetch/execute sequencer and its
// surroundings (byte-wide instruction source, data memory, extended ALU, debug taps).
//   instr_byte/instr_valid/instr_ready : byte stream of 16-bit instructions, low byte first
//   m_in                               : RAM[A] read data, stable during EXEC
//   alu_x/alu_y/alu_instr              : operands and 9-bit instruction sent to the ALU
//   alu_out/alu_zr/alu_ng              : ALU result and flags
//   write_m/m_out/addr_m               : one-cycle memory write strobe, data, address
//   pc/a_reg/d_reg                     : program counter and architectural registers
// Modports: master = environment (byte source, memory, ALU); slave = sequencer.
interface hack_sequencer_if;
  logic [7:0]  instr_byte;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] m_in;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [8:0]  alu_instr;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic        write_m;
  logic [15:0] m_out;
  logic [14:0] addr_m;
  logic [14:0] pc;
  logic [15:0] a_reg;
  logic [15:0] d_reg;

  modport master (
    output instr_byte, instr_valid, m_in, alu_out, alu_zr, alu_ng,
    input  instr_ready, alu_x, alu_y, alu_instr, write_m, m_out, addr_m, pc, a_reg, d_reg
  );

  modport slave (
    input  instr_byte, instr_valid, m_in, alu_out, alu_zr, alu_ng,
    output instr_ready, alu_x, alu_y, alu_instr, write_m, m_out, addr_m, pc, a_reg, d_reg
  );
endinterface

// File: rtl/hack_sequencer.sv
// hack_sequencer: multi-cycle fetch/execute sequencer for the extended Hack CPU.
// Streams each 16-bit instruction in as two bytes (FETCH_LO, FETCH_HI), then spends one EXEC
// cycle driving the external combinational ALU and committing its result to A, D, memory and pc.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   io_seq : hack_sequencer_if.slave (byte link, memory, ALU and debug signals)
module hack_sequencer (
  input  logic             clk,
  input  logic             rst_n,
  hack_sequencer_if.slave  io_seq
);

  typedef enum logic [1:0] {StFetchLo, StFetchHi, StExec} state_e;

  state_e      r_state, w_state_next;
  logic [15:0] r_ir, w_ir_next;
  logic [15:0] r_a, w_a_next;
  logic [15:0] r_d, w_d_next;
  logic [14:0] r_pc, w_pc_next;

  logic        w_ready;
  logic        w_write_m;
  logic        w_is_c;
  logic        w_dest_a, w_dest_d, w_dest_m;
  logic        w_take;
  logic [14:0] w_pc_inc;

  assign w_is_c   = r_ir[15];
  assign w_dest_a = r_ir[5];
  assign w_dest_d = r_ir[4];
  assign w_dest_m = r_ir[3];
  assign w_pc_inc = r_pc + 15'd1;  // wraps modulo 2^15

  // Jump bits are {lt, eq, gt}, evaluated against the flags the ALU returns.
  assign w_take = (r_ir[2] & io_seq.alu_ng) | (r_ir[1] & io_seq.alu_zr) |
                  (r_ir[0] & ~io_seq.alu_ng & ~io_seq.alu_zr);

  always_comb begin
    w_state_next = r_state;
    w_ir_next    = r_ir;
    w_a_next     = r_a;
    w_d_next     = r_d;
    w_pc_next    = r_pc;
    w_ready      = 1'b0;
    w_write_m    = 1'b0;
    unique case (r_state)
      StFetchLo: begin
        w_ready = 1'b1;
        if (io_seq.instr_valid) begin
          w_ir_next[7:0] = io_seq.instr_byte;
          w_state_next   = StFetchHi;
        end
      end
      StFetchHi: begin
        w_ready = 1'b1;
        if (io_seq.instr_valid) begin
          w_ir_next[15:8] = io_seq.instr_byte;
          w_state_next    = StExec;
        end
      end
      StExec: begin
        w_state_next = StFetchLo;
        if (!w_is_c) begin
          w_a_next  = {1'b0, r_ir[14:0]};
          w_pc_next = w_pc_inc;
        end else begin
          if (w_dest_a) w_a_next = io_seq.alu_out;
          if (w_dest_d) w_d_next = io_seq.alu_out;
          w_write_m = w_dest_m;
          // Jump target is the A value from before this instruction's commit.
          w_pc_next = w_take ? r_a[14:0] : w_pc_inc;
        end
      end
      default: w_state_next = StFetchLo;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetchLo;
      r_ir    <= 16'd0;
      r_a     <= 16'd0;
      r_d     <= 16'd0;
      r_pc    <= 15'd0;
    end else begin
      r_state <= w_state_next;
      r_ir    <= w_ir_next;
      r_a     <= w_a_next;
      r_d     <= w_d_next;
      r_pc    <= w_pc_next;
    end
  end

  // Decode is always live so the ALU sees the current ir/A/D even in fetch states.
  assign io_seq.instr_ready = w_ready;
  assign io_seq.write_m     = w_write_m;
  assign io_seq.alu_x       = r_d;
  assign io_seq.alu_y       = r_ir[12] ? io_seq.m_in : r_a;
  assign io_seq.alu_instr   = r_ir[14:6];
  assign io_seq.m_out       = io_seq.alu_out;
  assign io_seq.addr_m      = r_a[14:0];
  assign io_seq.pc          = r_pc;
  assign io_seq.a_reg       = r_a;
  assign io_seq.d_reg       = r_d;

endmodule

// File: tb/tb_hack_sequencer.sv
// tb_hack_sequencer: directed and random instruction streams for hack_sequencer, checked
// against an instruction-level reference model of the A/D/pc architectural state.
module tb_hack_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hack_sequencer_if bus ();

  hack_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_seq (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference architectural state.
  logic [15:0] ma, md;
  logic [14:0] mpc;

  // Stand-in for the extended ALU: standard Hack ALU for prefix 11, arithmetic shift of x
  // right by one for every other prefix.
  function automatic logic [15:0] alu_f(input logic [8:0] op, input logic [15:0] x,
                                        input logic [15:0] y);
    logic [15:0] xx, yy, r;
    if (op[8:7] != 2'b11) return 16'($signed(x) >>> 1);
    xx = op[5] ? 16'd0 : x;
    xx = op[4] ? ~xx : xx;
    yy = op[3] ? 16'd0 : y;
    yy = op[2] ? ~yy : yy;
    r  = op[1] ? xx + yy : xx & yy;
    return op[0] ? ~r : r;
  endfunction

  always_comb begin
    logic [15:0] r;
    r = alu_f(bus.alu_instr, bus.alu_x, bus.alu_y);
    bus.alu_out = r;
    bus.alu_zr  = (r == 16'd0);
    bus.alu_ng  = r[15];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_arch(input string tag);
    check({tag, "_pc"}, 32'(bus.pc), 32'(mpc));
    check({tag, "_a"}, 32'(bus.a_reg), 32'(ma));
    check({tag, "_d"}, 32'(bus.d_reg), 32'(md));
  endtask

  task automatic model_reset();
    ma  = 16'd0;
    md  = 16'd0;
    mpc = 15'd0;
  endtask

  // Feeds one instruction. Called and returns at #1 after a rising edge, DUT in FETCH_LO.
  // rst_mode: 0 none, 1 reset after the low byte, 2 reset during EXEC.
  task automatic send(input logic [15:0] ins, input int st_lo, input int st_hi,
                      input int rst_mode);
    logic [15:0] y, r;
    logic        take;
    for (int i = 0; i < st_lo; i++) begin
      bus.instr_valid = 1'b0;
      bus.instr_byte  = 8'($urandom);
      #1;
      check("lo_stall_ready", 32'(bus.instr_ready), 32'd1);
      check("lo_stall_wm", 32'(bus.write_m), 32'd0);
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b1;
    bus.instr_byte  = ins[7:0];
    #1;
    check("lo_ready", 32'(bus.instr_ready), 32'd1);
    check("lo_wm", 32'(bus.write_m), 32'd0);
    @(posedge clk); #1;
    if (rst_mode == 1) begin
      rst_n = 1'b0;
      bus.instr_valid = 1'b0;
      #1;
      model_reset();
      check_arch("rst_lo");
      check("rst_lo_ready", 32'(bus.instr_ready), 32'd1);
      check("rst_lo_ir", 32'(bus.alu_instr), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end
    for (int i = 0; i < st_hi; i++) begin
      bus.instr_valid = 1'b0;
      bus.instr_byte  = 8'($urandom);
      #1;
      check("hi_stall_ready", 32'(bus.instr_ready), 32'd1);
      check("hi_stall_wm", 32'(bus.write_m), 32'd0);
      check_arch("hi_stall");
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b1;
    bus.instr_byte  = ins[15:8];
    #1;
    check("hi_ready", 32'(bus.instr_ready), 32'd1);
    check("hi_wm", 32'(bus.write_m), 32'd0);
    @(posedge clk); #1;
    // EXEC: offer a junk byte that must be refused.
    bus.instr_valid = 1'($urandom);
    bus.instr_byte  = 8'($urandom);
    bus.m_in        = 16'($urandom);
    #1;
    check("exec_ready", 32'(bus.instr_ready), 32'd0);
    if (ins[15]) begin
      y    = ins[12] ? bus.m_in : ma;
      r    = alu_f(ins[14:6], md, y);
      take = (ins[2] && $signed(r) < 0) || (ins[1] && r == 16'd0) ||
             (ins[0] && $signed(r) > 0);
      check("exec_alu_x", 32'(bus.alu_x), 32'(md));
      check("exec_alu_y", 32'(bus.alu_y), 32'(y));
      check("exec_alu_instr", 32'(bus.alu_instr), 32'(ins[14:6]));
      check("exec_wm", 32'(bus.write_m), 32'(ins[3]));
      if (ins[3]) begin
        check("exec_addr_m", 32'(bus.addr_m), 32'(ma[14:0]));
        check("exec_m_out", 32'(bus.m_out), 32'(r));
      end
      mpc = take ? ma[14:0] : mpc + 15'd1;
      if (ins[5]) ma = r;
      if (ins[4]) md = r;
    end else begin
      check("exec_wm_a", 32'(bus.write_m), 32'd0);
      ma  = {1'b0, ins[14:0]};
      mpc = mpc + 15'd1;
    end
    if (rst_mode == 2) begin
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_exec_wm", 32'(bus.write_m), 32'd0);
      check_arch("rst_exec");
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end
    @(posedge clk); #1;
    check_arch("commit");
  endtask

  initial begin
    logic [15:0] ins;
    bus.instr_valid = 1'b0;
    bus.instr_byte  = 8'd0;
    bus.m_in        = 16'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_arch("reset");
    check("reset_wm", 32'(bus.write_m), 32'd0);
    check("reset_ready", 32'(bus.instr_ready), 32'd1);
    check("reset_addr_m", 32'(bus.addr_m), 32'd0);
    check("reset_m_out", 32'(bus.m_out), 32'(alu_f(9'd0, 16'd0, 16'd0)));

    // @5 ; D=A
    send(16'h0005, 0, 0, 0);
    send(16'hEC10, 0, 0, 0);
    check("dir_a5", 32'(bus.a_reg), 32'h0005);
    check("dir_d5", 32'(bus.d_reg), 32'h0005);
    check("dir_pc2", 32'(bus.pc), 32'd2);

    // @100 ; M=D
    send(16'h0064, 0, 0, 0);
    send(16'hE308, 0, 0, 0);

    // @6 ; D=-A ; D=D>>>1 ; @7 ; D;JLT
    send(16'h0006, 0, 0, 0);
    send(16'hECD0, 0, 0, 0);
    check("dir_dfffa", 32'(bus.d_reg), 32'hFFFA);
    send(16'hA410, 0, 0, 0);
    check("dir_dfffd", 32'(bus.d_reg), 32'hFFFD);
    send(16'h0007, 0, 0, 0);
    send(16'hE304, 0, 0, 0);
    check("dir_jlt_pc", 32'(bus.pc), 32'd7);

    // @3 ; AM=A+1;JMP
    send(16'h0003, 0, 0, 0);
    send(16'hEDEF, 0, 0, 0);
    check("dir_jmp_pc", 32'(bus.pc), 32'd3);
    check("dir_jmp_a", 32'(bus.a_reg), 32'h0004);

    // pc wrap: @7FFF ; 0;JMP ; @1
    send(16'h7FFF, 0, 0, 0);
    send(16'hEA87, 0, 0, 0);
    check("dir_pc7fff", 32'(bus.pc), 32'h7FFF);
    send(16'h0001, 0, 0, 0);
    check("dir_pc_wrap", 32'(bus.pc), 32'd0);

    // Throttled bytes
    send(16'h1234, 2, 5, 0);

    // Reset during EXEC of M=D, then after a partial low byte
    send(16'h0064, 0, 0, 0);
    send(16'hE308, 0, 0, 2);
    send(16'hFFFF, 0, 0, 1);
    send(16'h0042, 0, 0, 0);
    check("dir_after_rst_a", 32'(bus.a_reg), 32'h0042);
    check("dir_after_rst_pc", 32'(bus.pc), 32'd1);

    // Random stream
    for (int n = 0; n < 200; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(1, 0) == 0) ins[15] = 1'b0;
      else if ($urandom_range(1, 0) == 0) ins[14:13] = 2'b11;
      send(ins, ($urandom_range(3, 0) == 0) ? $urandom_range(2, 1) : 0,
           ($urandom_range(3, 0) == 0) ? $urandom_range(2, 1) : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
